// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: streams an 8-word block from pipelined memory into the cache
// data array, then writes valid+tag when the last word lands. Stalls the pipe via fsm_busy.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLK = 8,
    parameter int OFS_W         = 3,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic              fsm_busy,
    output logic [ADDR_W-1:0] fill_address,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_data_array,
    output logic              write_tag_array
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [OFS_W:0]    BLK      = (OFS_W+1)'(WORDS_PER_BLK);
    localparam logic [OFS_W:0]    LAST     = (OFS_W+1)'(WORDS_PER_BLK - 1);
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(WORDS_PER_BLK - 1);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [OFS_W:0]    req_cnt;
    logic [OFS_W:0]    rcv_cnt;

    logic filling;
    logic req_open;
    logic accept;
    logic last_word;

    assign filling  = (state == FILL);
    assign req_open = filling && (req_cnt < BLK);
    // A return may pair with the request issued in the same cycle (zero-latency memory).
    assign accept    = filling && mem_data_valid && ((rcv_cnt < req_cnt) || req_open);
    assign last_word = accept && (rcv_cnt == LAST);

    // base has zero low bits, so the add never carries out of the offset field.
    assign mem_read_en      = req_open;
    assign mem_address      = filling ? base + ADDR_W'(req_open ? req_cnt : LAST) : '0;
    assign fsm_busy         = filling;
    assign fill_address     = filling ? base + ADDR_W'(rcv_cnt) : '0;
    assign fill_data        = accept ? mem_data : '0;
    assign write_data_array = accept;
    assign write_tag_array  = last_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            req_cnt <= '0;
            rcv_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base    <= miss_address & ~OFS_MASK;
                        req_cnt <= '0;
                        rcv_cnt <= '0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (req_open)  req_cnt <= req_cnt + 1'b1;
                    if (accept)    rcv_cnt <= rcv_cnt + 1'b1;
                    if (last_word) state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
